// File: rtl/eth_rx_frame_sched_if.sv
// FIFO read port and framed output stream of the RX frame scheduler.
// master = scheduler side, slave = FIFO/consumer side.
interface eth_rx_frame_sched_if;
  logic        fifo_rd_en;
  logic        fifo_rd_vld;
  logic [31:0] fifo_rd_data;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_sop;
  logic        m_eop;
  logic [3:0]  m_keep;

  modport master (
    output fifo_rd_en,
    input  fifo_rd_vld,
    input  fifo_rd_data,
    output m_data,
    output m_valid,
    input  m_ready,
    output m_sop,
    output m_eop,
    output m_keep
  );

  modport slave (
    input  fifo_rd_en,
    output fifo_rd_vld,
    output fifo_rd_data,
    input  m_data,
    input  m_valid,
    output m_ready,
    input  m_sop,
    input  m_eop,
    input  m_keep
  );
endinterface

// File: rtl/eth_rx_frame_sched.sv
// Ethernet RX read-side frame scheduler: parses header words from the prefetch FIFO,
// forwards payload as a sop/eop/keep stream and discards malformed or oversize frames.
module eth_rx_frame_sched #(
  parameter int unsigned MAX_LEN = 1518,
  parameter logic [15:0] MAGIC   = 16'hA55A
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst_n,
  input  logic                  en,
  eth_rx_frame_sched_if.master  bus,
  output logic                  busy,
  output logic [15:0]           frame_cnt,
  output logic [15:0]           drop_cnt,
  output logic [15:0]           sync_err_cnt
);

  localparam logic [15:0] MaxLen = 16'(MAX_LEN);

  typedef enum logic [1:0] {StIdle, StHdr, StPayload, StDrop} state_e;

  state_e      state_q, state_d;
  logic [14:0] cnt_q;
  logic [1:0]  lsb_q;
  logic        first_q;
  logic [31:0] m_data_q;
  logic        m_valid_q, m_sop_q, m_eop_q;
  logic [3:0]  m_keep_q;

  logic        rd_en;
  logic        load, cnt_ld, cnt_dec, hdr_ok;
  logic        inc_frame, inc_drop, inc_sync;

  logic [15:0] hdr_magic, hdr_len;
  logic [16:0] len_sum;
  logic [14:0] hdr_words;
  logic        last_word;
  logic [3:0]  eop_keep;

  assign hdr_magic = bus.fifo_rd_data[31:16];
  assign hdr_len   = bus.fifo_rd_data[15:0];
  // 17-bit sum so L up to 65535 rounds up without overflow
  assign len_sum   = {1'b0, hdr_len} + 17'd3;
  assign hdr_words = len_sum[16:2];
  assign last_word = (cnt_q == 15'd1);

  always_comb begin
    unique case (lsb_q)
      2'd1:    eop_keep = 4'h8;
      2'd2:    eop_keep = 4'hC;
      2'd3:    eop_keep = 4'hE;
      default: eop_keep = 4'hF;
    endcase
  end

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) state_q <= StIdle;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    rd_en     = 1'b0;
    load      = 1'b0;
    cnt_ld    = 1'b0;
    cnt_dec   = 1'b0;
    hdr_ok    = 1'b0;
    inc_frame = 1'b0;
    inc_drop  = 1'b0;
    inc_sync  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (en) state_d = StHdr;
      end
      StHdr: begin
        rd_en = 1'b1;
        if (bus.fifo_rd_vld) begin
          if (hdr_magic != MAGIC) begin
            inc_sync = 1'b1;
          end else if (hdr_len == 16'd0) begin
            inc_drop = 1'b1;
            if (!en) state_d = StIdle;
          end else if (hdr_len > MaxLen) begin
            cnt_ld  = 1'b1;
            state_d = StDrop;
          end else begin
            cnt_ld  = 1'b1;
            hdr_ok  = 1'b1;
            state_d = StPayload;
          end
        end
      end
      StPayload: begin
        rd_en = !m_valid_q || bus.m_ready;
        if (rd_en && bus.fifo_rd_vld) begin
          load    = 1'b1;
          cnt_dec = 1'b1;
          if (last_word) begin
            inc_frame = 1'b1;
            state_d   = en ? StHdr : StIdle;
          end
        end
      end
      StDrop: begin
        rd_en = 1'b1;
        if (bus.fifo_rd_vld) begin
          cnt_dec = 1'b1;
          if (last_word) begin
            inc_drop = 1'b1;
            state_d  = en ? StHdr : StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      cnt_q        <= '0;
      lsb_q        <= '0;
      first_q      <= 1'b0;
      m_data_q     <= '0;
      m_valid_q    <= 1'b0;
      m_sop_q      <= 1'b0;
      m_eop_q      <= 1'b0;
      m_keep_q     <= '0;
      frame_cnt    <= '0;
      drop_cnt     <= '0;
      sync_err_cnt <= '0;
    end else begin
      if (cnt_ld)       cnt_q <= hdr_words;
      else if (cnt_dec) cnt_q <= cnt_q - 15'd1;

      if (hdr_ok) begin
        lsb_q   <= hdr_len[1:0];
        first_q <= 1'b1;
      end else if (load) begin
        first_q <= 1'b0;
      end

      // Flags stay put after acceptance; they are only meaningful with m_valid.
      if (load) begin
        m_data_q  <= bus.fifo_rd_data;
        m_valid_q <= 1'b1;
        m_sop_q   <= first_q;
        m_eop_q   <= last_word;
        m_keep_q  <= last_word ? eop_keep : 4'hF;
      end else if (bus.m_ready) begin
        m_valid_q <= 1'b0;
      end

      if (inc_frame) frame_cnt    <= frame_cnt + 16'd1;
      if (inc_drop)  drop_cnt     <= drop_cnt + 16'd1;
      if (inc_sync)  sync_err_cnt <= sync_err_cnt + 16'd1;
    end
  end

  assign bus.fifo_rd_en = rd_en;
  assign bus.m_data     = m_data_q;
  assign bus.m_valid    = m_valid_q;
  assign bus.m_sop      = m_sop_q;
  assign bus.m_eop      = m_eop_q;
  assign bus.m_keep     = m_keep_q;
  assign busy           = (state_q != StIdle);

endmodule

// File: tb/tb_eth_rx_frame_sched.sv
// Directed bench for eth_rx_frame_sched: FIFO model feeds words, expected beats are
// queued alongside the stimulus and checked as the consumer accepts them.
module tb_eth_rx_frame_sched;
  logic        rd_clk = 1'b0;
  logic        rd_rst_n = 1'b0;
  logic        en = 1'b0;
  logic        busy;
  logic [15:0] frame_cnt, drop_cnt, sync_err_cnt;

  eth_rx_frame_sched_if bus ();

  eth_rx_frame_sched #(.MAX_LEN(1518), .MAGIC(16'hA55A)) dut (
    .rd_clk       (rd_clk),
    .rd_rst_n     (rd_rst_n),
    .en           (en),
    .bus          (bus.master),
    .busy         (busy),
    .frame_cnt    (frame_cnt),
    .drop_cnt     (drop_cnt),
    .sync_err_cnt (sync_err_cnt)
  );

  always #5 rd_clk = ~rd_clk;

  int n_checks = 0;
  int n_pass = 0;
  int n_fail = 0;

  logic [31:0] fifo_q[$];
  logic [37:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // FIFO model: pop on a consumed word, present the head #1 after each edge.
  initial begin
    bus.fifo_rd_vld  = 1'b0;
    bus.fifo_rd_data = '0;
    forever begin
      logic took;
      @(posedge rd_clk);
      took = bus.fifo_rd_en && bus.fifo_rd_vld && rd_rst_n;
      #1;
      if (took && fifo_q.size() > 0) void'(fifo_q.pop_front());
      bus.fifo_rd_vld  = (fifo_q.size() > 0);
      bus.fifo_rd_data = (fifo_q.size() > 0) ? fifo_q[0] : 32'h0;
    end
  end

  // Consumer: every accepted beat must match the scoreboard head; stalled beats must hold.
  logic        prev_stall = 1'b0;
  logic [37:0] prev_beat = '0;
  always @(negedge rd_clk) begin
    logic [37:0] beat;
    beat = {bus.m_data, bus.m_sop, bus.m_eop, bus.m_keep};
    if (!rd_rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 64'(bus.m_valid), 64'd1);
        check("hold_beat", 64'(beat), 64'(prev_beat));
      end
      if (bus.m_valid && bus.m_ready) begin
        if (exp_q.size() == 0) check("unexpected_beat", 64'(beat), 64'h0);
        else check("beat", 64'(beat), 64'(exp_q.pop_front()));
      end
      prev_stall = bus.m_valid && !bus.m_ready;
      prev_beat  = beat;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge rd_clk);
      #1;
    end
  endtask

  task automatic exp_beat(input logic [31:0] d, input logic sop, input logic eop,
                          input logic [3:0] keep);
    exp_q.push_back({d, sop, eop, keep});
  endtask

  task automatic wait_drain(input string tag, input int limit);
    int i;
    i = 0;
    while ((exp_q.size() != 0 || fifo_q.size() != 0 || bus.m_valid) && i < limit) begin
      tick(1);
      i++;
    end
    check(tag, 64'(i < limit), 64'd1);
    tick(2);
  endtask

  initial begin
    bus.m_ready = 1'b1;
    tick(3);
    check("rst_rd_en", 64'(bus.fifo_rd_en), 64'd0);
    check("rst_out", 64'({bus.m_valid, bus.m_sop, bus.m_eop, bus.m_keep, bus.m_data}), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_cnts", 64'({frame_cnt, drop_cnt, sync_err_cnt}), 64'd0);
    rd_rst_n = 1'b1;
    tick(2);

    // Basic 6-byte frame
    fifo_q.push_back(32'hA55A0006);
    fifo_q.push_back(32'h11223344);
    fifo_q.push_back(32'h55660000);
    exp_beat(32'h11223344, 1'b1, 1'b0, 4'hF);
    exp_beat(32'h55660000, 1'b0, 1'b1, 4'hC);
    en = 1'b1;
    wait_drain("drain_t1", 50);
    check("t1_frame_cnt", 64'(frame_cnt), 64'd1);

    // Backpressure 1,0,0,1
    fifo_q.push_back(32'hA55A0008);
    fifo_q.push_back(32'hCAFE0001);
    fifo_q.push_back(32'hCAFE0002);
    exp_beat(32'hCAFE0001, 1'b1, 1'b0, 4'hF);
    exp_beat(32'hCAFE0002, 1'b0, 1'b1, 4'hF);
    tick(3);
    bus.m_ready = 1'b0;
    tick(2);
    bus.m_ready = 1'b1;
    wait_drain("drain_t2", 50);
    check("t2_frame_cnt", 64'(frame_cnt), 64'd2);

    // Oversize frame discarded, then a short frame
    fifo_q.push_back(32'hA55A05F0);
    for (int i = 0; i < 380; i++) fifo_q.push_back($urandom);
    fifo_q.push_back(32'hA55A0004);
    fifo_q.push_back(32'hDEADBEEF);
    exp_beat(32'hDEADBEEF, 1'b1, 1'b1, 4'hF);
    wait_drain("drain_t3", 1000);
    check("t3_drop_cnt", 64'(drop_cnt), 64'd1);
    check("t3_frame_cnt", 64'(frame_cnt), 64'd3);

    // Bad magic, zero length, 1-byte frame
    fifo_q.push_back(32'h12345678);
    fifo_q.push_back(32'hA55A0000);
    fifo_q.push_back(32'hA55A0001);
    fifo_q.push_back(32'hAB000000);
    exp_beat(32'hAB000000, 1'b1, 1'b1, 4'h8);
    wait_drain("drain_t4", 50);
    check("t4_sync_err", 64'(sync_err_cnt), 64'd1);
    check("t4_drop_cnt", 64'(drop_cnt), 64'd2);
    check("t4_frame_cnt", 64'(frame_cnt), 64'd4);

    // en dropped mid-payload: frame completes, next header left in FIFO
    bus.m_ready = 1'b0;
    fifo_q.push_back(32'hA55A000F);
    for (int i = 0; i < 4; i++) begin
      fifo_q.push_back(32'h0BAD0000 + 32'(i));
      exp_beat(32'h0BAD0000 + 32'(i), i == 0, i == 3, (i == 3) ? 4'hE : 4'hF);
    end
    fifo_q.push_back(32'hA55A0004);
    fifo_q.push_back(32'h99999999);
    tick(5);
    check("t5_busy_mid", 64'(busy), 64'd1);
    en = 1'b0;
    tick(1);
    bus.m_ready = 1'b1;
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick(1);
    tick(4);
    check("t5_drained", 64'(exp_q.size()), 64'd0);
    check("t5_busy", 64'(busy), 64'd0);
    check("t5_rd_en", 64'(bus.fifo_rd_en), 64'd0);
    check("t5_fifo_left", 64'(fifo_q.size()), 64'd2);
    check("t5_frame_cnt", 64'(frame_cnt), 64'd5);

    // Reset mid-payload: leftover header + word are the frame in flight
    bus.m_ready = 1'b0;
    en = 1'b1;
    tick(4);
    check("t6_valid_pre", 64'(bus.m_valid), 64'd1);
    #2;
    rd_rst_n = 1'b0;
    #1;
    check("t6_rst_out",
          64'({bus.fifo_rd_en, bus.m_valid, bus.m_sop, bus.m_eop, bus.m_keep, bus.m_data}),
          64'd0);
    check("t6_rst_busy", 64'(busy), 64'd0);
    check("t6_rst_cnts", 64'({frame_cnt, drop_cnt, sync_err_cnt}), 64'd0);
    fifo_q.delete();
    tick(2);
    rd_rst_n = 1'b1;
    bus.m_ready = 1'b1;

    // Restart after reset
    fifo_q.push_back(32'hA55A0002);
    fifo_q.push_back(32'h77880000);
    exp_beat(32'h77880000, 1'b1, 1'b1, 4'hC);
    wait_drain("drain_t7", 50);
    check("t7_frame_cnt", 64'(frame_cnt), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    check("global_timeout", 64'd1, 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/eth_rx_frame_sched.md
# eth_rx_frame_sched

Read-side frame scheduler for the Ethernet RX buffer. Pops 32-bit words from the prefetch FIFO (rd_en/rd_vld/rd_data), parses a per-frame header word, forwards the payload downstream as a framed stream with sop/eop/keep, and discards malformed or oversize frames. Sits in the rd_clk domain between the RX buffer and the packet consumer, and provides pause-at-frame-boundary control and statistics.

## Interface
- MAX_LEN, 1518: largest accepted frame length in bytes; range 1..65535.
- MAGIC, 16'hA55A: required value of header bits [31:16].
- rd_clk  in  1  block clock, same clock as the FIFO read side.
- rd_rst_n  in  1  asynchronous active-low reset.
- en  in  1  scheduler enable; sampled only at frame boundaries.
- fifo_rd_en  out  1  pop request to the FIFO.
- fifo_rd_vld  in  1  FIFO head word valid.
- fifo_rd_data  in  32  FIFO head word.
- m_data  out  32  payload word; byte 0 in [31:24].
- m_valid  out  1  m_data valid.
- m_ready  in  1  downstream accept.
- m_sop  out  1  first word of frame, qualified by m_valid.
- m_eop  out  1  last word of frame, qualified by m_valid.
- m_keep  out  4  byte enables, MSB = byte 0; 4'hF except on the eop word.
- busy  out  1  state != IDLE.
- frame_cnt  out  16  frames forwarded, wraps.
- drop_cnt  out  16  frames discarded (length 0 or > MAX_LEN), wraps.
- sync_err_cnt  out  16  header words rejected for bad magic, wraps.

## Operation
- Word consumed iff fifo_rd_en && fifo_rd_vld in the same cycle. fifo_rd_en may be high while fifo_rd_vld is low (no effect).
- Header word: [31:16] magic, [15:0] byte length L. Payload word count W = (L+3)>>2, 15-bit-safe arithmetic (17-bit internal sum).
- States: IDLE, HDR, PAYLOAD, DROP.
- IDLE: fifo_rd_en=0. en=1 -> HDR next cycle.
- HDR: fifo_rd_en=1. On consumed word:
  - magic != MAGIC: sync_err_cnt+1, stay HDR (hunt).
  - L == 0: drop_cnt+1, go IDLE if en=0, else stay HDR.
  - L > MAX_LEN: load word counter with W, go DROP.
  - else: load counter with W, latch L[1:0], set first flag, go PAYLOAD.
- PAYLOAD: fifo_rd_en = !m_valid || m_ready. Each consumed word loads the output register: m_sop=first flag (then cleared), m_eop=(counter==1), m_keep on eop from L[1:0]: 0->F, 1->8, 2->C, 3->E. Counter decrements per consumed word. On consuming last word: frame_cnt+1, go HDR if en=1 else IDLE.
- DROP: fifo_rd_en=1; counter decrements per consumed word; on last: drop_cnt+1, go HDR/IDLE per en. Nothing reaches m_*.
- Output register: m_valid set on load, cleared when m_ready && no new load that cycle. Holds data/flags stable while m_valid && !m_ready.
- en deasserted mid-frame: current frame completes (forwarded or dropped), then IDLE. en never truncates a frame.

## Timing
- Reset: state IDLE; fifo_rd_en=0, m_valid=0, m_sop=0, m_eop=0, m_keep=0, m_data=0, busy=0, all counters 0, word counter 0.
- Reset mid-frame: all state cleared immediately; partial frame is not flushed; header parsing restarts at the next FIFO word after en.
- Latency: FIFO word consumed at edge N appears on m_* after edge N (valid during cycle N+1).
- Throughput: one payload word per cycle when fifo_rd_vld and m_ready held high; header costs one cycle per frame; back-to-back frames allowed, no idle cycles except the header.
- Last payload word and next header: header consumed earliest the cycle after the last payload word.
- Counters update on the edge that consumes the deciding word; a forwarded frame is counted when its eop word is loaded, not when accepted.
- m_ready low with m_valid high: fifo_rd_en=0, no word consumed.

## Test plan
- Reset then en=1, FIFO holds {A55A,0006},11223344,55660000, m_ready=1 -> two beats: 11223344 sop=1 eop=0 keep=F; 55660000 sop=0 eop=1 keep=C; frame_cnt=1.
- Header {A55A,0008} with m_ready toggling 1,0,0,1 -> each word held stable while m_ready=0, exactly two beats, no word lost or duplicated.
- Header {A55A,05F0} (1520 > 1518) followed by 380 words then {A55A,0004},DEADBEEF -> 380 words discarded, drop_cnt=1, one beat DEADBEEF sop=eop=1 keep=F.
- Words 12345678, {A55A,0000}, {A55A,0001},AB000000 -> sync_err_cnt=1, drop_cnt=1, one beat keep=8 sop=eop=1.
- en deasserted during 4-word payload -> remaining words forwarded, then busy=0, fifo_rd_en=0 with FIFO non-empty.
- rd_rst_n asserted mid-payload -> all outputs at reset values asynchronously; counters 0.
